// File: rtl/run_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// run_ctrl_pkg
//   Shared definitions for the run/cont/halt job-control FSM.
//   Holds the state encoding, the watchdog counter width and a small helper
//   that tells whether a state counts as "busy" for the front panel.
// ---------------------------------------------------------------------------
package run_ctrl_pkg;

    // Width of the state register and of the cs status port
    localparam int STATE_W = 3;

    // Width of the pause watchdog counter (WDOG_CYC must fit below 2^WDOG_W)
    localparam int WDOG_W = 16;

    // Encodings are fixed because cs is visible on the front panel;
    // 110 and 111 are unused and steer back to IDLE.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'b000,
        ST_RUN   = 3'b001,
        ST_PAUSE = 3'b010,
        ST_HALT  = 3'b011,
        ST_DONE  = 3'b100,
        ST_FAULT = 3'b101
    } state_e;

    // A job is in flight while it is running or parked in PAUSE
    function automatic logic isBusy(input logic [STATE_W-1:0] s);
        return (s == ST_RUN) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/run_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// run_ctrl_fsm
//   Job sequencer that sits between the lab front-panel controls and the
//   datapath they gate. A job of len_q cycles runs through
//   IDLE -> RUN (<-> PAUSE) -> DONE, can be aborted into HALT at any time,
//   and, with the pause watchdog built in, drops into FAULT when left in
//   PAUSE for too long.
//
//   Optional feature macro: RUN_CTRL_WDOG_EN
//     defined   : PAUSE is timed; after WDOG_CYC cycles without cont/halt
//                 the FSM enters FAULT, which only halt (or reset) leaves.
//     undefined : PAUSE waits forever, FAULT is unreachable, fault = 0.
//
//   Parameters
//     CNT_W     width of len/step_cnt (job length up to 2^CNT_W-1 cycles)
//     WDOG_CYC  PAUSE cycles before FAULT, 1 .. 2^16-1
//
//   Ports
//     clk       in   rising-edge clock
//     reset     in   asynchronous, active-low reset
//     run       in   level: start a job / keep running; low in RUN pauses
//     cont      in   level: resume from PAUSE, release from HALT
//     halt      in   level: abort, highest priority in every state
//     len       in   job length, captured only on IDLE -> RUN
//     cs        out  registered state encoding
//     step_cnt  out  completed RUN cycles of the current job (registered)
//     busy      out  1 in RUN or PAUSE
//     done      out  1 in DONE
//     fault     out  1 in FAULT (always 0 without the watchdog)
// ---------------------------------------------------------------------------
module run_ctrl_fsm
    import run_ctrl_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int WDOG_CYC = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               cont,
    input  logic               halt,
    input  logic [CNT_W-1:0]   len,
    output logic [STATE_W-1:0] cs,
    output logic [CNT_W-1:0]   step_cnt,
    output logic               busy,
    output logic               done,
    output logic               fault
);

    // Reject parameter values the counters cannot represent at elaboration
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("run_ctrl_fsm: CNT_W must be at least 1");
    end
    if ((WDOG_CYC < 1) || (WDOG_CYC > 65535)) begin : g_bad_wdog_cyc
        $error("run_ctrl_fsm: WDOG_CYC must be in 1..65535");
    end

    state_e           cs_q,   cs_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] len_q,  len_d;

`ifdef RUN_CTRL_WDOG_EN
    // Last watchdog count value before the FSM gives up on the pause
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

    // State, step counter, captured length and watchdog all live here.
    // Reset is asynchronous so pulling reset low stops the job at once,
    // without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_q   <= ST_IDLE;
            step_q <= '0;
            len_q  <= '0;
`ifdef RUN_CTRL_WDOG_EN
            wdog_q <= '0;
`endif
        end else begin
            cs_q   <= cs_d;
            step_q <= step_d;
            len_q  <= len_d;
`ifdef RUN_CTRL_WDOG_EN
            wdog_q <= wdog_d;
`endif
        end
    end

    // Next-state and counter update. Every state checks halt first, then
    // cont, then run. Entering or sitting in HALT clears the step counter
    // so an aborted job never leaves a stale count on the panel. The
    // watchdog defaults to zero, so it clears whenever PAUSE is left.
    always_comb begin
        cs_d   = cs_q;
        step_d = step_q;
        len_d  = len_q;
`ifdef RUN_CTRL_WDOG_EN
        wdog_d = '0;
`endif

        case (cs_q)
            ST_IDLE: begin
                if (halt) begin
                    cs_d   = ST_HALT;
                    step_d = '0;
                end else if (run) begin
                    len_d  = len;
                    step_d = '0;
                    // A zero-length job has nothing to run and completes at once
                    cs_d   = (len != '0) ? ST_RUN : ST_DONE;
                end
            end

            ST_RUN: begin
                if (halt) begin
                    cs_d   = ST_HALT;
                    step_d = '0;
                end else if (!run) begin
                    // Pausing takes precedence over this cycle's increment
                    cs_d = ST_PAUSE;
                end else begin
                    step_d = step_q + CNT_W'(1);
                    if (step_q == (len_q - CNT_W'(1))) begin
                        cs_d = ST_DONE;
                    end
                end
            end

            ST_PAUSE: begin
                if (halt) begin
                    cs_d   = ST_HALT;
                    step_d = '0;
                end else if (cont) begin
                    cs_d = ST_RUN;
`ifdef RUN_CTRL_WDOG_EN
                end else if (wdog_q == WDOG_LAST) begin
                    cs_d = ST_FAULT;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
`endif
                end
            end

            ST_HALT: begin
                step_d = '0;
                if (cont && !halt) begin
                    cs_d = ST_IDLE;
                end
            end

            ST_DONE: begin
                if (halt) begin
                    cs_d   = ST_HALT;
                    step_d = '0;
                end else if (!run) begin
                    // Run must drop before a new job can start from IDLE
                    cs_d = ST_IDLE;
                end
            end

`ifdef RUN_CTRL_WDOG_EN
            ST_FAULT: begin
                // Only an explicit abort clears a watchdog fault
                if (halt) begin
                    cs_d   = ST_HALT;
                    step_d = '0;
                end
            end
`endif

            default: begin
                cs_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are plain decodes of the registered state
    assign cs       = cs_q;
    assign step_cnt = step_q;
    assign busy     = isBusy(cs_q);
    assign done     = (cs_q == ST_DONE);
`ifdef RUN_CTRL_WDOG_EN
    assign fault    = (cs_q == ST_FAULT);
`else
    assign fault    = 1'b0;
`endif

endmodule

// File: tb/tb_run_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_run_ctrl_fsm
//   Directed bench for run_ctrl_fsm. Inputs change 1 time unit after a
//   rising edge; outputs are compared 1 time unit after each edge.
//   Watchdog scenario follows RUN_CTRL_WDOG_EN (WDOG_CYC = 4 here).
// ---------------------------------------------------------------------------
module tb_run_ctrl_fsm;

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_RUN   = 3'b001;
    localparam logic [2:0] S_PAUSE = 3'b010;
    localparam logic [2:0] S_HALT  = 3'b011;
    localparam logic [2:0] S_DONE  = 3'b100;
    localparam logic [2:0] S_FAULT = 3'b101;

    logic       clk;
    logic       reset;
    logic       run;
    logic       cont;
    logic       halt;
    logic [7:0] len;
    logic [2:0] cs;
    logic [7:0] stepCnt;
    logic       busy;
    logic       done;
    logic       fault;

    int checks   = 0;
    int failures = 0;

    run_ctrl_fsm #(
        .CNT_W    (8),
        .WDOG_CYC (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .cont     (cont),
        .halt     (halt),
        .len      (len),
        .cs       (cs),
        .step_cnt (stepCnt),
        .busy     (busy),
        .done     (done),
        .fault    (fault)
    );

    // 10-unit free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the front-panel inputs
    task automatic applyStimulus(input logic r, input logic c, input logic h, input logic [7:0] l);
        run  = r;
        cont = c;
        halt = h;
        len  = l;
    endtask

    // Advance n rising edges and settle 1 unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare every output against the expected state and step count
    task automatic checkOutput(input string tag, input logic [2:0] expCs, input logic [7:0] expStep);
        logic expBusy;
        logic expDone;
        logic expFault;
        expBusy  = (expCs == S_RUN) || (expCs == S_PAUSE);
        expDone  = (expCs == S_DONE);
        expFault = (expCs == S_FAULT);

        checks++;
        assert (cs === expCs) else begin
            failures++;
            $error("[TB] FAIL %s cs observed=%b expected=%b", tag, cs, expCs);
        end
        checks++;
        assert (stepCnt === expStep) else begin
            failures++;
            $error("[TB] FAIL %s step_cnt observed=%0d expected=%0d", tag, stepCnt, expStep);
        end
        checks++;
        assert (busy === expBusy) else begin
            failures++;
            $error("[TB] FAIL %s busy observed=%b expected=%b", tag, busy, expBusy);
        end
        checks++;
        assert (done === expDone) else begin
            failures++;
            $error("[TB] FAIL %s done observed=%b expected=%b", tag, done, expDone);
        end
        checks++;
        assert (fault === expFault) else begin
            failures++;
            $error("[TB] FAIL %s fault observed=%b expected=%b", tag, fault, expFault);
        end
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);

        // Reset held low for two cycles, then released with inputs idle
        $display("[TB] reset");
        #1;
        checkOutput("rst_async", S_IDLE, 8'd0);
        tick(2);
        checkOutput("rst_held", S_IDLE, 8'd0);
        reset = 1'b1;
        tick(1);
        checkOutput("rst_idle1", S_IDLE, 8'd0);
        tick(1);
        checkOutput("rst_idle2", S_IDLE, 8'd0);

        // len=5, run held 7 cycles: five RUN cycles then DONE
        $display("[TB] len=5 full job");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd5);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checkOutput($sformatf("j5_run%0d", i), S_RUN, 8'(i));
        end
        tick(1);
        checkOutput("j5_done", S_DONE, 8'd5);
        tick(1);
        checkOutput("j5_done_hold", S_DONE, 8'd5);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd5);
        tick(1);
        checkOutput("j5_idle", S_IDLE, 8'd5);

        // len=8, pause after 3 steps, resume with cont; len change ignored
        $display("[TB] len=8 pause/resume");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd8);
        tick(1);
        checkOutput("j8_run0", S_RUN, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd2);
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            checkOutput($sformatf("j8_run%0d", i), S_RUN, 8'(i));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd2);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checkOutput($sformatf("j8_pause%0d", i), S_PAUSE, 8'd3);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd2);
        tick(1);
        checkOutput("j8_resume", S_RUN, 8'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd2);
        for (int i = 4; i <= 7; i++) begin
            tick(1);
            checkOutput($sformatf("j8_run%0d", i), S_RUN, 8'(i));
        end
        tick(1);
        checkOutput("j8_done", S_DONE, 8'd8);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        tick(1);
        checkOutput("j8_idle", S_IDLE, 8'd8);

        // len=10, halt together with cont at step 4: halt wins
        $display("[TB] len=10 halt");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd10);
        for (int i = 0; i <= 4; i++) begin
            tick(1);
            checkOutput($sformatf("j10_run%0d", i), S_RUN, 8'(i));
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd10);
        tick(1);
        checkOutput("j10_halt", S_HALT, 8'd0);
        tick(1);
        checkOutput("j10_halt_hold", S_HALT, 8'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd10);
        tick(1);
        checkOutput("j10_release", S_IDLE, 8'd0);

        // len=0 goes straight to DONE; len=1 runs exactly one cycle
        $display("[TB] len=0 and len=1");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        tick(1);
        checkOutput("j0_done", S_DONE, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        tick(1);
        checkOutput("j0_idle", S_IDLE, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd1);
        tick(1);
        checkOutput("j1_run", S_RUN, 8'd0);
        tick(1);
        checkOutput("j1_done", S_DONE, 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd1);
        tick(1);
        checkOutput("j1_idle", S_IDLE, 8'd1);

        // Pause and hold: watchdog fault, or indefinite pause without it
        $display("[TB] pause hold");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd20);
        tick(1);
        checkOutput("wd_run0", S_RUN, 8'd0);
        tick(1);
        checkOutput("wd_run1", S_RUN, 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd20);
        tick(1);
        checkOutput("wd_pause0", S_PAUSE, 8'd1);
`ifdef RUN_CTRL_WDOG_EN
        for (int i = 1; i < 4; i++) begin
            tick(1);
            checkOutput($sformatf("wd_pause%0d", i), S_PAUSE, 8'd1);
        end
        tick(1);
        checkOutput("wd_fault", S_FAULT, 8'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd20);
        tick(1);
        checkOutput("wd_fault_cont", S_FAULT, 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd20);
        tick(1);
        checkOutput("wd_fault_halt", S_HALT, 8'd0);
`else
        // run alone must not resume a paused job
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd20);
        for (int i = 1; i <= 100; i++) begin
            tick(1);
            if ((i % 10) == 0) begin
                checkOutput($sformatf("wd_pause%0d", i), S_PAUSE, 8'd1);
            end
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd20);
        tick(1);
        checkOutput("wd_resume", S_RUN, 8'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd20);
        tick(1);
        checkOutput("wd_run2", S_RUN, 8'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd20);
        tick(1);
        checkOutput("wd_halt", S_HALT, 8'd0);
`endif
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd20);
        tick(1);
        checkOutput("wd_release", S_IDLE, 8'd0);

        // Asynchronous reset between edges in the middle of a job
        $display("[TB] async reset mid-run");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd10);
        tick(1);
        checkOutput("ar_run0", S_RUN, 8'd0);
        tick(1);
        checkOutput("ar_run1", S_RUN, 8'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("ar_async", S_IDLE, 8'd0);
        tick(1);
        checkOutput("ar_held", S_IDLE, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        reset = 1'b1;
        tick(1);
        checkOutput("ar_after", S_IDLE, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
